// File: rtl/dmem_block_memory_pkg.sv
// ============================================================================
// Module      : dmem_block_memory_pkg
// Description : Shared constants for the block-granular data memory: block
//               and address widths, default latencies, FSM state encodings
//               and a helper for sizing the latency counter.
//               The optional statistics feature of the memory is enabled
//               with the DMEM_STATS_EN macro (see dmem_block_memory.sv).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

// 20-bit byte address minus 4 block-offset bits
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 16
`endif

package dmem_block_memory_pkg;

    localparam int unsigned C_BLOCK_BITS      = `DBLOCK_SIZE_BITS;
    localparam int unsigned C_BLOCK_ADDR_W    = `DMEM_BLOCK_ADDR_SIZE;
    localparam int unsigned C_DEPTH_LOG2      = 10;
    localparam int unsigned C_READ_LATENCY    = 10;
    localparam int unsigned C_WRITE_LATENCY   = 10;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RBUSY = 3'd1;
    localparam logic [2:0] ST_WBUSY = 3'd2;
    localparam logic [2:0] ST_RDONE = 3'd3;
    localparam logic [2:0] ST_WDONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RBUSY = ST_RBUSY,
        S_WBUSY = ST_WBUSY,
        S_RDONE = ST_RDONE,
        S_WDONE = ST_WDONE
    } dmem_state_e;

    // Counter width able to hold (max latency - 1); never narrower than 1.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_latency_counter.sv
// ============================================================================
// Module      : dmem_latency_counter
// Description : Loadable down-counter with zero flag, used to time both read
//               and write latencies of dmem_block_memory.
// Ports       : clock, reset      - clock / synchronous active-high reset
//               load_i, load_val_i - load a new count (has priority)
//               dec_i              - decrement by one, stops at zero
//               zero_o             - count is zero
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_latency_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/dmem_block_memory.sv
// ============================================================================
// Module      : dmem_block_memory
// Description : Block-granular main data memory behind the L1 D-cache
//               controller. Serves block fills (memRen) and dirty writebacks
//               (memWen) with fixed, configurable latency; a pulse on
//               memReadReady / memWriteDone marks completion.
// Ports       : clock, reset               - clock / sync active-high reset
//               memRen, memWen             - level-held requests
//               BlockAddr, memDin          - block address / writeback data
//               memReadReady, memWriteDone - one-cycle completion pulses
//               memDout                    - last read block (held)
//               rdCount, wrCount, abortCount (only with DMEM_STATS_EN)
// Options     : DMEM_STATS_EN - adds read/write/abort statistics outputs
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_block_memory
    import dmem_block_memory_pkg::*;
#(
    parameter int unsigned BLOCK_ADDR_W  = C_BLOCK_ADDR_W,
    parameter int unsigned BLOCK_BITS    = C_BLOCK_BITS,
    parameter int unsigned DEPTH_LOG2    = C_DEPTH_LOG2,
    parameter int unsigned READ_LATENCY  = C_READ_LATENCY,   // >= 1
    parameter int unsigned WRITE_LATENCY = C_WRITE_LATENCY   // >= 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    memRen,
    input  logic                    memWen,
    input  logic [BLOCK_ADDR_W-1:0] BlockAddr,
    input  logic [BLOCK_BITS-1:0]   memDin,
    output logic                    memReadReady,
    output logic                    memWriteDone,
    output logic [BLOCK_BITS-1:0]   memDout
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]             rdCount,
    output logic [31:0]             wrCount,
    output logic [15:0]             abortCount
`endif
);

    localparam int unsigned       CNT_W     = cnt_width(READ_LATENCY, WRITE_LATENCY);
    localparam logic [CNT_W-1:0]  C_RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]  C_WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    dmem_state_e                state_q;
    dmem_state_e                state_d;

    logic [DEPTH_LOG2-1:0]      idx_q;
    logic [BLOCK_BITS-1:0]      din_q;
    logic [BLOCK_BITS-1:0]      mem_q [2**DEPTH_LOG2];
    logic                       rd_ready_q;
    logic                       wr_done_q;
    logic [BLOCK_BITS-1:0]      dout_q;

    logic                       w_cnt_load;
    logic [CNT_W-1:0]           w_cnt_val;
    logic                       w_cnt_dec;
    logic                       w_cnt_zero;
    logic                       w_capture_rd;
    logic                       w_capture_wr;
    logic                       w_rd_fire;
    logic                       w_wr_fire;
    logic                       w_abort;

    // Upper address bits alias onto the implemented depth on purpose.
    generate
        if (DEPTH_LOG2 < BLOCK_ADDR_W) begin : g_addr_alias
            logic w_unused_upper_addr;
            assign w_unused_upper_addr = ^BlockAddr[BLOCK_ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    dmem_latency_counter #(
        .WIDTH      (CNT_W)
    ) u_lat_cnt (
        .clock      (clock),
        .reset      (reset),
        .load_i     (w_cnt_load),
        .load_val_i (w_cnt_val),
        .dec_i      (w_cnt_dec),
        .zero_o     (w_cnt_zero)
    );

    // Next-state and control. A write beats a simultaneous read so that the
    // dirty victim is written back before the fill of the same block.
    always_comb begin
        state_d      = state_q;
        w_cnt_load   = 1'b0;
        w_cnt_val    = '0;
        w_cnt_dec    = 1'b0;
        w_capture_rd = 1'b0;
        w_capture_wr = 1'b0;
        w_rd_fire    = 1'b0;
        w_wr_fire    = 1'b0;
        w_abort      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (memWen) begin
                    w_capture_wr = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = C_WR_LOAD;
                    state_d      = S_WBUSY;
                end else if (memRen) begin
                    w_capture_rd = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = C_RD_LOAD;
                    state_d      = S_RBUSY;
                end
            end
            S_RBUSY: begin
                if (!memRen) begin
                    w_abort = 1'b1;
                    state_d = S_IDLE;
                end else if (w_cnt_zero) begin
                    w_rd_fire = 1'b1;
                    state_d   = S_RDONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            S_WBUSY: begin
                if (!memWen) begin
                    w_abort = 1'b1;
                    state_d = S_IDLE;
                end else if (w_cnt_zero) begin
                    w_wr_fire = 1'b1;
                    state_d   = S_WDONE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            // Hold here until the served request drops so a still-held
            // request is not serviced twice.
            S_RDONE: begin
                if (!memRen) begin
                    state_d = S_IDLE;
                end
            end
            S_WDONE: begin
                if (!memWen) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches: later changes on the bus are ignored.
    always_ff @(posedge clock) begin
        if (w_capture_rd || w_capture_wr) begin
            idx_q <= BlockAddr[DEPTH_LOG2-1:0];
        end
        if (w_capture_wr) begin
            din_q <= memDin;
        end
    end

    // Storage is not reset; a commit coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (w_wr_fire && !reset) begin
            mem_q[idx_q] <= din_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ready_q <= 1'b0;
            wr_done_q  <= 1'b0;
            dout_q     <= '0;
        end else begin
            rd_ready_q <= w_rd_fire;
            wr_done_q  <= w_wr_fire;
            if (w_rd_fire) begin
                dout_q <= mem_q[idx_q];
            end
        end
    end

    assign memReadReady = rd_ready_q;
    assign memWriteDone = wr_done_q;
    assign memDout      = dout_q;

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;
    logic [15:0] abort_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count_q    <= '0;
            wr_count_q    <= '0;
            abort_count_q <= '0;
        end else begin
            if (w_rd_fire) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (w_wr_fire) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (w_abort && (abort_count_q != 16'hFFFF)) begin
                abort_count_q <= abort_count_q + 16'd1;
            end
        end
    end

    assign rdCount    = rd_count_q;
    assign wrCount    = wr_count_q;
    assign abortCount = abort_count_q;
`else
    logic w_unused_abort;
    assign w_unused_abort = w_abort;
`endif

endmodule

`default_nettype wire
